dma_sample_unpacker: RTL and testbench

//  Downstream consumer of the simple DMA read controller. Keeps a small FIFO of 64-bit

---
 rtl/dma_sample_unpacker.sv | 188 ++++++++++++++++++
 tb/tb_dma_sample_unpacker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sample_unpacker.sv
// DMA word prefetch FIFO that unpacks 64-bit words into 16-bit PCM samples.
// Optional DMA_UNPACK_STATS_EN adds saturating underrun/overflow event counters.
module dma_sample_unpacker #(
   parameter int DEPTH     = 4,
   parameter int MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [63:0] data,
   input  logic        data_ready,
   output logic        request,
   input  logic        sample_tick,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic        underrun,
`ifdef DMA_UNPACK_STATS_EN
   output logic        overflow,
   output logic [15:0] underrun_cnt,
   output logic [15:0] overflow_cnt
`else
   output logic        overflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [1:0]    half_q, half_d;
   logic          request_q, request_d;
   logic [15:0]   sample_q, sample_d;
   logic          valid_q, valid_d;
   logic          underrun_q, underrun_d;
   logic          overflow_q, overflow_d;

   logic          empty, full;
   logic          tick_ok, tick_empty;
   logic          push, pop, drop;
   logic [63:0]   head;
   logic [15:0]   half_sel;
   logic [CW:0]   inflight;

   always_comb begin
      empty      = (count_q == '0);
      full       = (count_q == DEPTH_C);
      tick_ok    = sample_tick && !empty;
      tick_empty = sample_tick && empty;
      pop        = tick_ok && (half_q == 2'd3);
      // a pop in the same cycle frees the slot for the incoming word
      push       = data_ready && (!full || pop);
      drop       = data_ready && full && !pop;
      head       = mem_q[rd_ptr_q];
      inflight   = {1'b0, count_q} + {1'b0, outst_q};
   end

   always_comb begin
      half_sel = head[63:48];
      unique case (half_q)
         2'd0: half_sel = head[63:48];
         2'd1: half_sel = head[47:32];
         2'd2: half_sel = head[31:16];
         2'd3: half_sel = head[15:0];
      endcase
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      half_d   = half_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (tick_ok) begin
         half_d = half_q + 2'd1;
      end
   end

   always_comb begin
      outst_d = outst_q;
      // late words after reset must not drive outst below zero
      if (request_q && !data_ready) begin
         outst_d = outst_q + 1'b1;
      end else if (data_ready && !request_q && outst_q != '0) begin
         outst_d = outst_q - 1'b1;
      end
      request_d = enable
               && (inflight < {1'b0, DEPTH_C})
               && (outst_q < MAXO_C)
               && !request_q;
   end

   always_comb begin
      sample_d   = sample_q;
      valid_d    = sample_tick;
      underrun_d = underrun_q;
      overflow_d = overflow_q || drop;
      if (tick_ok) begin
         sample_d = half_sel;
      end else if (tick_empty) begin
         sample_d   = 16'h0000;
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         half_q     <= '0;
         request_q  <= 1'b0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         half_q     <= half_d;
         request_q  <= request_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   assign request      = request_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign underrun     = underrun_q;
   assign overflow     = overflow_q;

`ifdef DMA_UNPACK_STATS_EN
   logic [15:0] ucnt_q, ucnt_d;
   logic [15:0] ocnt_q, ocnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      ocnt_d = ocnt_q;
      if (tick_empty && ucnt_q != 16'hFFFF) begin
         ucnt_d = ucnt_q + 16'd1;
      end
      if (drop && ocnt_q != 16'hFFFF) begin
         ocnt_d = ocnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ucnt_q <= '0;
         ocnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
         ocnt_q <= ocnt_d;
      end
   end

   assign underrun_cnt = ucnt_q;
   assign overflow_cnt = ocnt_q;
`endif

endmodule

// File: tb/tb_dma_sample_unpacker.sv
// Bench for dma_sample_unpacker: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_dma_sample_unpacker;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [63:0] data = '0;
   logic        data_ready = 1'b0;
   logic        sample_tick = 1'b0;
   logic        request;
   logic [15:0] sample;
   logic        sample_valid;
   logic        underrun;
   logic        overflow;
`ifdef DMA_UNPACK_STATS_EN
   logic [15:0] underrun_cnt;
   logic [15:0] overflow_cnt;
`endif

   dma_sample_unpacker #(.DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .data         (data),
      .data_ready   (data_ready),
      .request      (request),
      .sample_tick  (sample_tick),
      .sample       (sample),
      .sample_valid (sample_valid),
      .underrun     (underrun),
`ifdef DMA_UNPACK_STATS_EN
      .overflow     (overflow),
      .underrun_cnt (underrun_cnt),
      .overflow_cnt (overflow_cnt)
`else
      .overflow     (overflow)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // reference model: words held in a queue, outputs derived from rules
   logic [63:0] mq[$];
   int          m_half, m_outst, m_ucnt, m_ocnt;
   bit          m_req, m_sv, m_und, m_ovf;
   logic [15:0] m_sample;

   task automatic model_step();
      bit          nreq;
      logic [63:0] w;
      if (rst) begin
         mq.delete();
         m_half = 0; m_outst = 0; m_ucnt = 0; m_ocnt = 0;
         m_req = 0; m_sv = 0; m_und = 0; m_ovf = 0; m_sample = '0;
      end else begin
         nreq = enable && (mq.size() + m_outst < DEPTH)
                && (m_outst < MAXO) && !m_req;
         if (m_req && !data_ready) m_outst++;
         else if (data_ready && !m_req && m_outst > 0) m_outst--;
         m_sv = sample_tick;
         if (sample_tick) begin
            if (mq.size() > 0) begin
               w = mq[0];
               m_sample = 16'(w >> (48 - 16 * m_half));
               m_half++;
               if (m_half == 4) begin
                  void'(mq.pop_front());
                  m_half = 0;
               end
            end else begin
               m_sample = '0;
               m_und = 1;
               m_ucnt++;
            end
         end
         if (data_ready) begin
            if (mq.size() < DEPTH) mq.push_back(data);
            else begin
               m_ovf = 1;
               m_ocnt++;
            end
         end
         m_req = nreq;
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (armed) begin
         chk("request", request, m_req);
         chk("sample", sample, m_sample);
         chk("sample_valid", sample_valid, m_sv);
         chk("underrun", underrun, m_und);
         chk("overflow", overflow, m_ovf);
`ifdef DMA_UNPACK_STATS_EN
         chk("underrun_cnt", underrun_cnt, (m_ucnt > 65535) ? 65535 : m_ucnt);
         chk("overflow_cnt", overflow_cnt, (m_ocnt > 65535) ? 65535 : m_ocnt);
`endif
      end
   end

   task automatic step(input bit r, input bit en, input bit dr,
                       input logic [63:0] d, input bit tk);
      rst = r;
      enable = en;
      data_ready = dr;
      data = d;
      sample_tick = tk;
      @(posedge clk);
      #1;
   endtask

   logic [63:0] W [6];
   logic [63:0] A [4];
   logic [63:0] X, Y, w;
   logic [15:0] exph;
   bit          pat [8];
   logic [15:0] h2 [4];
   int          backlog, returned, guard, cyc, last_due, tprob;
   bit          en_r, dr, r, tk;
   int          pend[$];

   initial begin
      W[0] = 64'h1111_2222_3333_4444;
      W[1] = 64'hAAAA_BBBB_CCCC_DDDD;
      W[2] = 64'h0102_0304_0506_0708;
      W[3] = 64'hDEAD_BEEF_CAFE_F00D;
      W[4] = 64'h5555_6666_7777_8888;
      W[5] = 64'h9999_0000_1234_5678;
      A[0] = 64'hA0A0_A1A1_A2A2_A3A3;
      A[1] = 64'hB0B0_B1B1_B2B2_B3B3;
      A[2] = 64'hC0C0_C1C1_C2C2_C3C3;
      A[3] = 64'hD0D0_D1D1_D2D2_D3D3;
      X = 64'hFEED_FACE_0BAD_C0DE;
      Y = 64'h7E57_0001_0002_0003;
      pat = '{1, 0, 1, 0, 0, 0, 0, 0};
      h2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

      step(1, 0, 0, '0, 0);
      armed = 1;
      chk("rst_request", request, 0);
      chk("rst_sample", sample, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_overflow", overflow, 0);

      // request pulses at cycles 1 and 3 only
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, '0, 0);
         chk("t1_req_pattern", request, pat[i]);
      end
      backlog = 2; returned = 0; guard = 0;
      while (returned < 4 && guard < 40) begin
         guard++;
         if (backlog > 0) begin
            backlog--;
            step(0, 1, 1, W[returned], 0);
            returned++;
         end else begin
            step(0, 1, 0, '0, 0);
         end
         if (request) backlog++;
      end
      chk("t1_returns", returned, 4);
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, '0, 0);
         chk("t1_full_no_req", request, 0);
      end

      // unpack order of first word
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, '0, 1);
         chk("t2_sample", sample, h2[i]);
         chk("t2_valid", sample_valid, 1);
      end
      step(0, 1, 0, '0, 0);
      chk("t2_req_after_pop", request, 1);
      chk("t2_valid_low", sample_valid, 0);
      step(0, 1, 1, W[4], 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0);

      // empty ticks
      step(1, 0, 0, '0, 0);
      step(0, 0, 0, '0, 1);
      chk("t3_sample", sample, 0);
      chk("t3_valid", sample_valid, 1);
      chk("t3_underrun", underrun, 1);
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);
`ifdef DMA_UNPACK_STATS_EN
      chk("t3_underrun_cnt", underrun_cnt, 3);
`endif
      step(0, 0, 1, W[5], 0);
      step(0, 0, 0, '0, 0);
      chk("t3_underrun_sticky", underrun, 1);

      // overflow drops a word; replay only the stored four
      step(1, 0, 0, '0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, A[i], 0);
      step(0, 0, 1, X, 0);
      chk("t4_overflow", overflow, 1);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, '0, 1);
         w = A[i / 4];
         exph = 16'(w >> (48 - 16 * (i % 4)));
         chk("t4_replay", sample, exph);
      end
      step(0, 0, 0, '0, 1);
      chk("t4_then_underrun", underrun, 1);
      chk("t4_then_zero", sample, 0);

      // pop and push together while full
      step(1, 0, 0, '0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, A[i], 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
      step(0, 0, 1, X, 1);
      chk("t5_no_overflow", overflow, 0);
      chk("t5_last_half", sample, A[0][15:0]);
      for (int i = 0; i < 16; i++) step(0, 0, 0, '0, 1);
      chk("t5_pushed_word", sample, X[15:0]);
      chk("t5_no_underrun", underrun, 0);

      // reset mid-transfer
      step(1, 0, 0, '0, 0);
      step(0, 0, 1, A[0], 0);
      step(0, 0, 1, A[1], 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, 0);
      step(1, 1, 0, '0, 0);
      chk("t6_request", request, 0);
      chk("t6_sample", sample, 0);
      chk("t6_valid", sample_valid, 0);
      chk("t6_underrun", underrun, 0);
      chk("t6_overflow", overflow, 0);
      step(0, 0, 1, Y, 0);
      step(0, 0, 0, '0, 1);
      chk("t6_late_word", sample, Y[63:48]);
      step(0, 1, 0, '0, 0);
      chk("t6_req1", request, 1);
      step(0, 1, 0, '0, 0);
      step(0, 1, 0, '0, 0);
      chk("t6_req2", request, 1);
      step(0, 1, 0, '0, 0);
      step(0, 1, 0, '0, 0);
      chk("t6_req_limit", request, 0);

      // randomized traffic with an in-order DMA responder
      step(1, 0, 0, '0, 0);
      cyc = 0; last_due = 0; en_r = 1; tprob = 25;
      for (int i = 0; i < 5000; i++) begin
         if (i % 500 == 0) tprob = (i / 500 % 3 == 0) ? 5 : (i / 500 % 3 == 1) ? 25 : 60;
         if ($urandom_range(0, 49) == 0) en_r = !en_r;
         dr = 0;
         if (pend.size() > 0 && pend[0] <= cyc) begin
            dr = 1;
            void'(pend.pop_front());
         end else if ($urandom_range(0, 99) < 2) begin
            dr = 1;
         end
         r = ($urandom_range(0, 499) == 0);
         tk = ($urandom_range(0, 99) < tprob);
         step(r, en_r, dr, {$urandom, $urandom}, tk);
         cyc++;
         if (request) begin
            last_due = (cyc + int'($urandom_range(1, 6)) > last_due + 1)
                       ? cyc + int'($urandom_range(1, 6)) : last_due + 1;
            pend.push_back(last_due);
         end
      end
      step(0, 0, 0, '0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
